// File: rtl/prng_sampler.sv
// rtl/prng_sampler.sv - Park-Miller PRNG controller producing unbiased samples in [0, n)
//
// Drives the seed/start handshake of a Park-Miller core (m = 2^31-1), chains
// every result back as the next seed, rejects draws that would bias the
// modulo, and reduces accepted draws with a shared 31-cycle restoring divider.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   en                  allow new draws to start
//   cfg_load            one-cycle pulse latching cfg_seed / cfg_n
//   cfg_seed, cfg_n     new seed and range bound n
//   prng_start/seed     request and seed towards the PRNG core
//   prng_done/rand      completion and result from the PRNG core
//   out_valid/ready     sample handshake, out_data in [0, n)
//   busy                high whenever the controller is not idle
//   rej_cnt             saturating rejection counter
//
// Optional feature macro: PRNG_SAMPLER_STATS_EN builds the rej_cnt counter;
// without it rej_cnt is tied to zero.
module prng_sampler #(
    parameter int          N_W      = 16,
    parameter logic [30:0] M_MINUS1 = 31'h7FFFFFFE
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic           cfg_load,
    input  logic [31:0]    cfg_seed,
    input  logic [N_W-1:0] cfg_n,
    output logic           prng_start,
    output logic [31:0]    prng_seed,
    input  logic           prng_done,
    input  logic [31:0]    prng_rand,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N_W-1:0] out_data,
    output logic           busy,
    output logic [15:0]    rej_cnt
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LIMIT  = 3'd1;
    localparam logic [2:0] S_REQ    = 3'd2;
    localparam logic [2:0] S_WAITLO = 3'd3;
    localparam logic [2:0] S_CHECK  = 3'd4;
    localparam logic [2:0] S_DIV    = 3'd5;
    localparam logic [2:0] S_OUT    = 3'd6;

    logic [2:0]     state;
    logic [N_W-1:0] n_q;
    logic [30:0]    limit_q;
    logic [31:0]    v_q;

    logic           pend;
    logic [31:0]    pend_seed;
    logic [N_W-1:0] pend_n;

    // Divider datapath: dividend shifts out MSB first into the remainder.
    logic [30:0]    dvd_q;
    logic [N_W-1:0] rem_q;
    logic [4:0]     cnt_q;

    logic           load_req;
    logic [31:0]    load_seed;
    logic [N_W-1:0] load_n;
    logic [31:0]    seed_fix;
    logic [N_W-1:0] n_fix;
    logic [N_W:0]   rem_sh;
    logic [N_W:0]   rem_nx;
    logic           div_last;
    logic           v_rej;
    logic           apply;

    always_comb begin
        // A fresh cfg_load always beats an older pending one.
        load_req  = cfg_load | pend;
        load_seed = cfg_load ? cfg_seed : pend_seed;
        load_n    = cfg_load ? cfg_n : pend_n;
        seed_fix  = ((load_seed == 32'd0) || (load_seed >= 32'h7FFFFFFF)) ? 32'd1 : load_seed;
        n_fix     = (load_n == '0) ? N_W'(1) : load_n;

        rem_sh    = {rem_q, dvd_q[30]};
        rem_nx    = (rem_sh >= {1'b0, n_q}) ? (rem_sh - {1'b0, n_q}) : rem_sh;
        div_last  = (cnt_q == 5'd30);

        v_rej     = (v_q >= {1'b0, limit_q});

        // A configuration can only take effect where no PRNG handshake is
        // open; otherwise it waits as pending. The end of DIV also counts, so
        // a sample computed for a superseded configuration is never shown.
        apply = 1'b0;
        case (state)
            S_IDLE, S_OUT, S_CHECK: apply = load_req;
            S_DIV:                  apply = load_req && div_last;
            default:                apply = 1'b0;
        endcase
    end

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            prng_start <= 1'b0;
            prng_seed  <= 32'd1;
            out_valid  <= 1'b0;
            out_data   <= '0;
            n_q        <= N_W'(1);
            limit_q    <= M_MINUS1;
            v_q        <= 32'd0;
            pend       <= 1'b0;
            pend_seed  <= 32'd0;
            pend_n     <= '0;
            dvd_q      <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
        end else begin
            if (cfg_load && !apply) begin
                pend      <= 1'b1;
                pend_seed <= cfg_seed;
                pend_n    <= cfg_n;
            end

            if (apply) begin
                pend      <= 1'b0;
                prng_seed <= seed_fix;
                n_q       <= n_fix;
                out_valid <= 1'b0;
                dvd_q     <= M_MINUS1;
                rem_q     <= '0;
                cnt_q     <= '0;
                state     <= S_LIMIT;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (en && !out_valid) begin
                            prng_start <= 1'b1;
                            state      <= S_REQ;
                        end
                    end

                    S_LIMIT: begin
                        rem_q <= rem_nx[N_W-1:0];
                        dvd_q <= {dvd_q[29:0], 1'b0};
                        cnt_q <= cnt_q + 5'd1;
                        if (div_last) begin
                            // Largest multiple of n not above the draw space.
                            limit_q <= M_MINUS1 - 31'(rem_nx);
                            state   <= S_IDLE;
                        end
                    end

                    S_REQ: begin
                        if (prng_done) begin
                            prng_start <= 1'b0;
                            state      <= S_WAITLO;
                        end
                    end

                    S_WAITLO: begin
                        if (!prng_done) begin
                            v_q       <= prng_rand - 32'd1;
                            prng_seed <= prng_rand;
                            state     <= S_CHECK;
                        end
                    end

                    S_CHECK: begin
                        if (v_rej) begin
                            if (en) begin
                                prng_start <= 1'b1;
                                state      <= S_REQ;
                            end else begin
                                state <= S_IDLE;
                            end
                        end else begin
                            dvd_q <= v_q[30:0];
                            rem_q <= '0;
                            cnt_q <= '0;
                            state <= S_DIV;
                        end
                    end

                    S_DIV: begin
                        rem_q <= rem_nx[N_W-1:0];
                        dvd_q <= {dvd_q[29:0], 1'b0};
                        cnt_q <= cnt_q + 5'd1;
                        if (div_last) begin
                            out_data  <= rem_nx[N_W-1:0];
                            out_valid <= 1'b1;
                            state     <= S_OUT;
                        end
                    end

                    S_OUT: begin
                        if (out_ready) begin
                            out_valid <= 1'b0;
                            if (en) begin
                                prng_start <= 1'b1;
                                state      <= S_REQ;
                            end else begin
                                state <= S_IDLE;
                            end
                        end
                    end

                    default: state <= S_IDLE;
                endcase
            end
        end
    end

`ifdef PRNG_SAMPLER_STATS_EN
    logic [15:0] rej_q;
    logic        rej_evt;

    assign rej_evt = (state == S_CHECK) && !load_req && v_rej;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rej_q <= 16'd0;
        end else if (cfg_load) begin
            rej_q <= 16'd0;
        end else if (rej_evt && (rej_q != 16'hFFFF)) begin
            rej_q <= rej_q + 16'd1;
        end
    end

    assign rej_cnt = rej_q;
`else
    assign rej_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_prng_sampler.sv
// tb/tb_prng_sampler.sv - self-checking bench for prng_sampler
`timescale 1ns/1ps
module tb_prng_sampler;
    localparam int N_W = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           en = 1'b0;
    logic           cfg_load = 1'b0;
    logic [31:0]    cfg_seed = 32'd0;
    logic [N_W-1:0] cfg_n = '0;
    logic           prng_start;
    logic [31:0]    prng_seed;
    logic           prng_done;
    logic [31:0]    prng_rand;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [N_W-1:0] out_data;
    logic           busy;
    logic [15:0]    rej_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    prng_sampler #(.N_W(N_W), .M_MINUS1(31'h7FFFFFFE)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .cfg_load(cfg_load), .cfg_seed(cfg_seed), .cfg_n(cfg_n),
        .prng_start(prng_start), .prng_seed(prng_seed),
        .prng_done(prng_done), .prng_rand(prng_rand),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .rej_cnt(rej_cnt)
    );

    // Reference arithmetic
    function automatic logic [31:0] pm(input logic [31:0] s);
        logic [63:0] p;
        p = {32'd0, s} * 64'd16807;
        p = p % 64'd2147483647;
        return p[31:0];
    endfunction

    function automatic logic [31:0] ref_seed(input logic [31:0] s);
        return ((s == 32'd0) || (s >= 32'h7FFFFFFF)) ? 32'd1 : s;
    endfunction

    // -1 means the draw is rejected
    function automatic int ref_out(input logic [31:0] r, input logic [N_W-1:0] n);
        logic [63:0] nn, v, lim;
        nn  = (n == '0) ? 64'd1 : {48'd0, n};
        v   = {32'd0, r} - 64'd1;
        lim = 64'h7FFFFFFE - (64'h7FFFFFFE % nn);
        if (v >= lim) return -1;
        return int'(v % nn);
    endfunction

    task automatic model_draw(inout logic [31:0] s, input logic [N_W-1:0] n,
                              output logic [N_W-1:0] e);
        int x;
        logic [31:0] r;
        x = -1;
        while (x < 0) begin
            r = pm(s);
            s = r;
            x = ref_out(r, n);
        end
        e = x[N_W-1:0];
    endtask

    // PRNG core stand-in: real Park-Miller or scripted results
    bit          stub_mode = 1'b0;
    logic [31:0] stub_q[$];
    logic [31:0] seed_log[$];
    int          stab_err = 0;
    int          rsp_st;
    int          rsp_lat;
    logic [31:0] rsp_seed;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prng_done <= 1'b0;
            prng_rand <= 32'd0;
            rsp_st    <= 0;
            rsp_lat   <= 0;
        end else begin
            case (rsp_st)
                0: if (prng_start) begin
                    seed_log.push_back(prng_seed);
                    rsp_seed <= prng_seed;
                    rsp_lat  <= int'($urandom_range(0, 3));
                    rsp_st   <= 1;
                end
                1: begin
                    if (prng_seed !== rsp_seed) stab_err <= stab_err + 1;
                    if (rsp_lat == 0) begin
                        prng_done <= 1'b1;
                        if (stub_mode && stub_q.size() > 0) prng_rand <= stub_q.pop_front();
                        else prng_rand <= pm(rsp_seed);
                        rsp_st <= 2;
                    end else begin
                        rsp_lat <= rsp_lat - 1;
                    end
                end
                default: if (!prng_start) begin
                    prng_done <= 1'b0;
                    rsp_st    <= 0;
                end
            endcase
        end
    end

    // Stimulus helpers
    task automatic cfg(input logic [31:0] s, input logic [N_W-1:0] n);
        @(negedge clk);
        cfg_seed = s;
        cfg_n    = n;
        cfg_load = 1'b1;
        @(negedge clk);
        cfg_load = 1'b0;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
    endtask

    task automatic accept(input int stall);
        repeat (stall) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic quiesce();
        en = 1'b0;
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            out_ready = out_valid;
            if (!busy && !out_valid) break;
        end
        out_ready = 1'b0;
        stub_q.delete();
        seed_log.delete();
    endtask

    // Scenarios
    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (prng_start !== 1'b0) begin errors++; $display("FAIL reset_start: got %0b expected 0", prng_start); end
        checks++; if (prng_seed !== 32'd1) begin errors++; $display("FAIL reset_seed: got %0h expected 1", prng_seed); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", out_valid); end
        checks++; if (out_data !== 16'd0) begin errors++; $display("FAIL reset_data: got %0h expected 0", out_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        checks++; if (rej_cnt !== 16'd0) begin errors++; $display("FAIL reset_rej: got %0h expected 0", rej_cnt); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_known();
        bit ok;
        quiesce();
        stub_mode = 1'b0;
        cfg(32'h7B818935, 16'd10);
        en = 1'b1;
        wait_valid(ok);
        en = 1'b0;
        checks++; if (!ok || out_data !== 16'd6) begin errors++; $display("FAIL known_n10: got %0d expected 6 (valid %0b)", out_data, ok); end
        checks++; if (prng_seed !== 32'h755735EB) begin errors++; $display("FAIL known_chain: got %0h expected 755735eb", prng_seed); end
        accept(0);

        quiesce();
        cfg(32'h7B818935, 16'd1000);
        en = 1'b1;
        wait_valid(ok);
        en = 1'b0;
        checks++; if (!ok || out_data !== 16'd706) begin errors++; $display("FAIL known_n1000: got %0d expected 706 (valid %0b)", out_data, ok); end
        accept(0);

        quiesce();
        cfg(32'h7B818935, 16'd0);
        en = 1'b1;
        wait_valid(ok);
        en = 1'b0;
        checks++; if (!ok || out_data !== 16'd0) begin errors++; $display("FAIL known_n0: got %0d expected 0 (valid %0b)", out_data, ok); end
        accept(0);
    endtask

    task automatic test_reject();
        bit ok;
        logic [15:0] exp_rej;
`ifdef PRNG_SAMPLER_STATS_EN
        exp_rej = 16'd1;
`else
        exp_rej = 16'd0;
`endif
        quiesce();
        stub_mode = 1'b1;
        stub_q.push_back(32'h7FFFFFFE);
        stub_q.push_back(32'h00012346);
        cfg(32'h00001234, 16'h8000);
        en = 1'b1;
        wait_valid(ok);
        en = 1'b0;
        checks++; if (!ok || out_data !== 16'h2345) begin errors++; $display("FAIL reject_data: got %0h expected 2345 (valid %0b)", out_data, ok); end
        checks++; if (seed_log.size() != 2) begin errors++; $display("FAIL reject_reqs: got %0d expected 2", seed_log.size()); end
        checks++; if (rej_cnt !== exp_rej) begin errors++; $display("FAIL reject_cnt: got %0d expected %0d", rej_cnt, exp_rej); end
        accept(0);
        quiesce();
        stub_mode = 1'b0;
    endtask

    task automatic test_chain();
        bit ok;
        logic [31:0] ms;
        logic [N_W-1:0] e;
        quiesce();
        ms = 32'h142E4ECE;
        cfg(32'h142E4ECE, 16'd7);
        en = 1'b1;
        model_draw(ms, 16'd7, e);
        wait_valid(ok);
        checks++; if (!ok || out_data !== e) begin errors++; $display("FAIL chain_s1: got %0d expected %0d", out_data, e); end
        accept(0);
        model_draw(ms, 16'd7, e);
        wait_valid(ok);
        en = 1'b0;
        checks++; if (!ok || out_data !== e) begin errors++; $display("FAIL chain_s2: got %0d expected %0d", out_data, e); end
        checks++; if (seed_log.size() < 2 || seed_log[0] !== 32'h142E4ECE || seed_log[1] !== 32'h6C37C0BB) begin
            errors++; $display("FAIL chain_seeds: got %0d seeds first %0h expected 142e4ece,6c37c0bb", seed_log.size(), prng_seed);
        end
        accept(0);
    endtask

    task automatic test_backpressure();
        bit ok, stable;
        int n0;
        logic [31:0] s, ms;
        logic [N_W-1:0] n, e, d0;
        quiesce();
        s  = $urandom;
        n  = N_W'($urandom_range(2, 60000));
        ms = ref_seed(s);
        model_draw(ms, n, e);
        cfg(s, n);
        en = 1'b1;
        wait_valid(ok);
        d0 = out_data;
        n0 = seed_log.size();
        stable = ok;
        repeat (20) begin
            @(negedge clk);
            if (!out_valid || out_data !== d0) stable = 1'b0;
        end
        en = 1'b0;
        checks++; if (!ok || d0 !== e) begin errors++; $display("FAIL bp_data: got %0d expected %0d", d0, e); end
        checks++; if (!stable) begin errors++; $display("FAIL bp_hold: got unstable output expected held %0d", d0); end
        checks++; if (seed_log.size() != n0) begin errors++; $display("FAIL bp_nostart: got %0d requests expected %0d", seed_log.size(), n0); end
        accept(0);
    endtask

    task automatic test_abort();
        bit ok, seen;
        logic [31:0] ms;
        logic [N_W-1:0] e;
        quiesce();
        cfg(32'h00BADA55, 16'd10);
        en = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (prng_start) begin
                seen = 1'b1;
                break;
            end
        end
        checks++; if (!seen) begin errors++; $display("FAIL abort_req: got no prng_start expected one"); end
        cfg_seed = 32'h0DEC0DE1;
        cfg_n    = 16'd10;
        cfg_load = 1'b1;
        @(negedge clk);
        cfg_load = 1'b0;
        ms = 32'h0DEC0DE1;
        model_draw(ms, 16'd10, e);
        wait_valid(ok);
        en = 1'b0;
        checks++; if (seed_log.size() != 2) begin errors++; $display("FAIL abort_reqs: got %0d requests expected 2", seed_log.size()); end
        checks++; if (seed_log.size() < 2 || seed_log[0] !== 32'h00BADA55 || seed_log[1] !== 32'h0DEC0DE1) begin
            errors++; $display("FAIL abort_seeds: got %0d seeds expected 00bada55,0dec0de1", seed_log.size());
        end
        checks++; if (!ok || out_data !== e) begin errors++; $display("FAIL abort_data: got %0d expected %0d", out_data, e); end
        accept(0);
    endtask

    task automatic test_seed_edge();
        logic [31:0] seeds [5];
        logic [31:0] exps  [5];
        seeds = '{32'h00000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFE, 32'h80000000};
        exps  = '{32'h00000001, 32'h00000001, 32'h00000001, 32'h7FFFFFFE, 32'h00000001};
        quiesce();
        for (int i = 0; i < 5; i++) begin
            cfg(seeds[i], 16'd3);
            checks++; if (prng_seed !== exps[i]) begin errors++; $display("FAIL seed_fix%0d: got %0h expected %0h", i, prng_seed, exps[i]); end
            wait_idle();
        end
    endtask

    task automatic test_random();
        bit ok;
        logic [31:0] s, ms;
        logic [N_W-1:0] n, e;
        for (int r = 0; r < 4; r++) begin
            quiesce();
            s  = $urandom;
            n  = (r % 2 == 0) ? N_W'($urandom_range(0, 20)) : N_W'($urandom);
            ms = ref_seed(s);
            cfg(s, n);
            en = 1'b1;
            for (int k = 0; k < 4; k++) begin
                model_draw(ms, n, e);
                wait_valid(ok);
                if (k == 3) en = 1'b0;
                checks++; if (!ok || out_data !== e) begin errors++; $display("FAIL rand_r%0d_k%0d: got %0d expected %0d (n %0d)", r, k, out_data, e, n); end
                accept(int'($urandom_range(0, 3)));
            end
        end
    endtask

    task automatic test_reset_div();
        bit seen;
        quiesce();
        cfg(32'h2468ACE1, 16'd100);
        en = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (prng_start) begin seen = 1'b1; break; end
        end
        for (int i = 0; i < 50 && seen; i++) begin
            @(negedge clk);
            if (!prng_start) break;
        end
        repeat (8) @(negedge clk);
        checks++; if (!seen || busy !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL rstdiv_pre: got busy %0b valid %0b expected busy 1 valid 0", busy, out_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || prng_start !== 1'b0) begin
            errors++; $display("FAIL rstdiv_out: got valid %0b start %0b expected 0 0", out_valid, prng_start);
        end
        checks++; if (busy !== 1'b0 || prng_seed !== 32'd1 || rej_cnt !== 16'd0) begin
            errors++; $display("FAIL rstdiv_state: got busy %0b seed %0h rej %0d expected 0 1 0", busy, prng_seed, rej_cnt);
        end
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_seed_stability();
        checks++; if (stab_err != 0) begin errors++; $display("FAIL seed_stable: got %0d changes expected 0", stab_err); end
    endtask

    initial begin
        test_reset();
        test_known();
        test_reject();
        test_chain();
        test_backpressure();
        test_abort();
        test_seed_edge();
        test_random();
        test_reset_div();
        test_seed_stability();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
